// File: rtl/if_prefetch_stage_pkg.sv
// Shared types for the instruction-fetch prefetch stage: FSM states, redirect
// sources and the prefetch-queue entry layout.
package if_prefetch_stage_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {RUN, DRAIN, SLEEP} if_state_e;

  typedef enum logic [1:0] {REDIR_NONE, REDIR_IRQ, REDIR_MRET, REDIR_BR} redir_src_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/if_prefetch_stage_if.sv
// Instruction-memory request/response port plus the ID-facing valid/ready port.
// master = fetch stage side, slave = memory/ID environment side.
interface if_prefetch_stage_if #(parameter int XLEN = 32);
  logic            im_req;
  logic [XLEN-1:0] im_addr;
  logic            im_gnt;
  logic            im_rvalid;
  logic [XLEN-1:0] im_rdata;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_inst;
  logic            id_ready;

  modport master (
    output im_req, im_addr, id_valid, id_pc, id_inst,
    input  im_gnt, im_rvalid, im_rdata, id_ready
  );

  modport slave (
    input  im_req, im_addr, id_valid, id_pc, id_inst,
    output im_gnt, im_rvalid, im_rdata, id_ready
  );
endinterface

// File: rtl/if_prefetch_stage_fifo.sv
// Synchronous FIFO with flush, occupancy count and full/empty flags; any DEPTH >= 1.
// Head is read combinationally; push is accepted when full only if a pop happens too.
module if_prefetch_stage_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          push_ok, pop_ok;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= nxt(wr_q);
      if (pop_ok)  rd_q <= nxt(rd_q);
      cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/if_prefetch_stage.sv
// RV32 fetch stage: credit-limited pipelined fetches into a prefetch queue, drop-count redirects, WFI sleep.
// Optional IF_PERF_CNT_EN adds saturating fetch/bubble/drop counters.
module if_prefetch_stage
  import if_prefetch_stage_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              FQ_DEPTH  = 4,
  parameter int              MAX_OUTST = 2,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst,
  if_prefetch_stage_if.master bus,
  input  logic            irq_take,
  input  logic [XLEN-1:0] irq_vec,
  input  logic            mret,
  input  logic [XLEN-1:0] mepc,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            wfi_req,
  output logic            sleeping
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_bubble_cnt,
  output logic [31:0]     perf_drop_cnt
`endif
);

  localparam int CW = $clog2(FQ_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTST + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } entry_t;

  if_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [OW-1:0]   outst_q, outst_d, drop_q, drop_d;
  redir_src_e      redir_src;
  logic [XLEN-1:0] redir_pc, resp_pc;
  logic            redir, fire, q_push, q_pop;
  logic            q_empty, q_full, pf_empty, pf_full;
  logic [CW-1:0]   q_count;
  logic [OW-1:0]   pf_count;
  entry_t          q_din, q_dout;

  always_comb begin
    redir_src = REDIR_NONE;
    redir_pc  = pc_q;
    if (irq_take) begin
      redir_src = REDIR_IRQ;
      redir_pc  = irq_vec;
    end else if (state_q == RUN && mret) begin
      redir_src = REDIR_MRET;
      redir_pc  = mepc;
    end else if (state_q == RUN && br_taken) begin
      redir_src = REDIR_BR;
      redir_pc  = br_target;
    end
  end

  assign redir = (redir_src != REDIR_NONE);

  // Queue slots are reserved for in-flight fetches so a response can always be pushed.
  assign bus.im_req = !rst && (state_q == RUN) && !redir
                      && (int'(q_count) + int'(outst_q) < FQ_DEPTH)
                      && (int'(outst_q) < MAX_OUTST);
  assign bus.im_addr = pc_q;
  assign fire        = bus.im_req && bus.im_gnt;

  assign q_push = bus.im_rvalid && (drop_q == '0) && !redir;
  assign q_pop  = bus.id_valid && bus.id_ready;
  assign q_din  = '{pc: resp_pc, inst: bus.im_rdata};

  assign bus.id_valid = !q_empty;
  assign bus.id_pc    = q_empty ? '0 : q_dout.pc;
  assign bus.id_inst  = q_empty ? '0 : q_dout.inst;
  assign sleeping     = (state_q == SLEEP);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    outst_d = outst_q + OW'(fire) - OW'(bus.im_rvalid);
    if (fire) pc_d = pc_q + XLEN'(4);
    if (redir) begin
      pc_d   = redir_pc;
      drop_d = outst_q - OW'(bus.im_rvalid);
    end else if (bus.im_rvalid && drop_q != '0) begin
      drop_d = drop_q - OW'(1);
    end
    case (state_q)
      RUN:     if (wfi_req) state_d = DRAIN;
      DRAIN:   if (outst_q == '0 && q_empty) state_d = SLEEP;
      SLEEP:   state_d = SLEEP;
      default: state_d = RUN;
    endcase
    if (irq_take) state_d = RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  if_prefetch_stage_fifo #(.W($bits(entry_t)), .DEPTH(FQ_DEPTH)) u_fq (
    .clk(clk), .rst(rst), .flush_i(redir),
    .push_i(q_push), .din_i(q_din), .pop_i(q_pop), .dout_o(q_dout),
    .count_o(q_count), .full_o(q_full), .empty_o(q_empty)
  );

  // PC of every granted fetch, popped by its response even when the data is dropped.
  if_prefetch_stage_fifo #(.W(XLEN), .DEPTH(MAX_OUTST)) u_pcf (
    .clk(clk), .rst(rst), .flush_i(1'b0),
    .push_i(fire), .din_i(pc_q), .pop_i(bus.im_rvalid), .dout_o(resp_pc),
    .count_o(pf_count), .full_o(pf_full), .empty_o(pf_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (int'(outst_q) <= MAX_OUTST);
      assert (int'(q_count) <= FQ_DEPTH);
      assert (!(bus.im_rvalid && outst_q == '0));
      assert (!(bus.im_rvalid && pf_empty));
      assert (!(fire && pf_full));
      assert (!(q_push && q_full && !q_pop));
      assert (pf_count == outst_q);
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q, drop_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      drop_cnt_q   <= '0;
    end else begin
      if (fire && fetch_cnt_q != '1) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (state_q == RUN && bus.id_ready && !bus.id_valid && bubble_cnt_q != '1)
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      if (bus.im_rvalid && (drop_q != '0 || redir) && drop_cnt_q != '1)
        drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt  = fetch_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
  assign perf_drop_cnt   = drop_cnt_q;
`endif

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage with a latency-programmable in-order memory model.
module tb_if_prefetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        irq_take, mret, br_taken, wfi_req, sleeping;
  logic [31:0] irq_vec, mepc, br_target;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_bubble_cnt, perf_drop_cnt;
`endif

  if_prefetch_stage_if #(.XLEN(32)) bus ();

  if_prefetch_stage #(.XLEN(32), .FQ_DEPTH(4), .MAX_OUTST(2), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .irq_take(irq_take), .irq_vec(irq_vec), .mret(mret), .mepc(mepc),
    .br_taken(br_taken), .br_target(br_target), .wfi_req(wfi_req), .sleeping(sleeping)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_bubble_cnt(perf_bubble_cnt),
    .perf_drop_cnt(perf_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          cyc_n = 0;
  int          lat = 1;
  logic [31:0] pend_a [$];
  int          pend_d [$];

  typedef struct {
    logic        rdy;
    logic        vld;
    logic [31:0] pc;
    logic        req;
    logic [31:0] addr;
  } vec_t;

  vec_t tbl [12];

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive_resp();
    if (pend_a.size() > 0 && pend_d[0] <= cyc_n) begin
      bus.im_rvalid = 1'b1;
      bus.im_rdata  = inst_of(pend_a[0]);
    end else begin
      bus.im_rvalid = 1'b0;
      bus.im_rdata  = '0;
    end
  endtask

  // One clock: record grant / response consumption before the edge, present responses after it.
  task automatic cyc();
    logic        f;
    logic [31:0] fa;
    #1;
    f  = bus.im_req && bus.im_gnt;
    fa = bus.im_addr;
    if (bus.im_rvalid) begin
      void'(pend_a.pop_front());
      void'(pend_d.pop_front());
    end
    if (f) begin
      pend_a.push_back(fa);
      pend_d.push_back(cyc_n + lat);
    end
    @(posedge clk);
    #1;
    cyc_n++;
    drive_resp();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    irq_take = 0; mret = 0; br_taken = 0; wfi_req = 0;
    pend_a.delete();
    pend_d.delete();
    bus.im_rvalid = 1'b0;
    bus.im_rdata  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_im_req", 32'(bus.im_req), 32'h0);
    chk("rst_id_valid", 32'(bus.id_valid), 32'h0);
    chk("rst_id_pc", bus.id_pc, 32'h0);
    chk("rst_id_inst", bus.id_inst, 32'h0);
    chk("rst_sleeping", 32'(sleeping), 32'h0);
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_valid(input string nm, input logic [31:0] exp_pc);
    int n = 0;
    while (!bus.id_valid && n < 40) begin
      cyc();
      n++;
    end
    if (!bus.id_valid) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_id_valid required=id_pc_%h", nm, exp_pc);
    end else begin
      chk({nm, "_pc"}, bus.id_pc, exp_pc);
      chk({nm, "_inst"}, bus.id_inst, inst_of(exp_pc));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=hung required=finish");
    $fatal(1);
  end

  initial begin
    bit saw_req;
    int n;
    // {id_ready, id_valid, id_pc, im_req, im_addr} per cycle after reset, 1-cycle memory
    tbl[0]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h00};
    tbl[1]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h04};
    tbl[2]  = '{1'b1, 1'b1, 32'h00, 1'b1, 32'h08};
    tbl[3]  = '{1'b1, 1'b1, 32'h04, 1'b1, 32'h0C};
    tbl[4]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h10};
    tbl[5]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h14};
    tbl[6]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h18};
    tbl[7]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h1C};
    tbl[8]  = '{1'b1, 1'b1, 32'h10, 1'b0, 32'h20};
    tbl[9]  = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h20};
    tbl[10] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h24};
    tbl[11] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h28};

    bus.im_gnt = 1'b1;
    bus.id_ready = 1'b1;
    irq_vec = '0; mepc = '0; br_target = '0;

    // Streaming with a short stall
    lat = 1;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      bus.id_ready = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d_vld", i), 32'(bus.id_valid), 32'(tbl[i].vld));
      if (tbl[i].vld) begin
        chk($sformatf("tbl%0d_pc", i), bus.id_pc, tbl[i].pc);
        chk($sformatf("tbl%0d_inst", i), bus.id_inst, inst_of(tbl[i].pc));
      end
      chk($sformatf("tbl%0d_req", i), 32'(bus.im_req), 32'(tbl[i].req));
      chk($sformatf("tbl%0d_addr", i), bus.im_addr, tbl[i].addr);
      cyc();
    end

    // ID stalled from reset: queue fills to 4 and fetching stops
    do_reset();
    bus.id_ready = 1'b0;
    repeat (10) cyc();
    chk("full_im_req", 32'(bus.im_req), 32'h0);
    chk("full_head_pc", bus.id_pc, 32'h0);
    bus.id_ready = 1'b1;
    #1;
    chk("full_pop_req", 32'(bus.im_req), 32'h0);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk($sformatf("drain%0d_vld", i), 32'(bus.id_valid), 32'h1);
      chk($sformatf("drain%0d_pc", i), bus.id_pc, 32'(i * 4));
    end

    // Branch with two fetches in flight
    lat = 3;
    do_reset();
    cyc();
    cyc();
    br_taken = 1'b1; br_target = 32'h100;
    #1;
    chk("br_req_off", 32'(bus.im_req), 32'h0);
    cyc();
    br_taken = 1'b0;
    n = 0;
    while (!bus.im_req && n < 10) begin
      cyc();
      n++;
    end
    chk("br_first_addr", bus.im_addr, 32'h100);
    wait_valid("br_tgt", 32'h100);
`ifdef IF_PERF_CNT_EN
    chk("br_drop_cnt", perf_drop_cnt, 32'd2);
`endif
    cyc();
    chk("br_next_vld", 32'(bus.id_valid), 32'h1);
    chk("br_next_pc", bus.id_pc, 32'h104);

    // irq beats a simultaneous branch, then mret
    irq_take = 1'b1; irq_vec = 32'h200;
    br_taken = 1'b1; br_target = 32'h300;
    #1;
    chk("irq_req_off", 32'(bus.im_req), 32'h0);
    cyc();
    irq_take = 1'b0; br_taken = 1'b0;
    wait_valid("irq_tgt", 32'h200);
    mret = 1'b1; mepc = 32'h40;
    cyc();
    mret = 1'b0;
    wait_valid("mret_tgt", 32'h40);

    // WFI with two fetches in flight
    lat = 2;
    do_reset();
    cyc();
    cyc();
    wfi_req = 1'b1;
    cyc();
    wfi_req = 1'b0;
    chk("drain_req", 32'(bus.im_req), 32'h0);
    chk("drain_pc0", bus.id_pc, 32'h0);
    cyc();
    chk("drain_pc4", bus.id_pc, 32'h4);
    chk("drain_not_asleep", 32'(sleeping), 32'h0);
    saw_req = 1'b0;
    n = 0;
    while (!sleeping && n < 20) begin
      if (bus.im_req) saw_req = 1'b1;
      cyc();
      n++;
    end
    chk("drain_no_req", 32'(saw_req), 32'h0);
    chk("sleep_on", 32'(sleeping), 32'h1);
    chk("sleep_req", 32'(bus.im_req), 32'h0);
    chk("sleep_empty", 32'(bus.id_valid), 32'h0);
    mret = 1'b1; mepc = 32'h40; br_taken = 1'b1; br_target = 32'h300;
    cyc();
    mret = 1'b0; br_taken = 1'b0;
    chk("sleep_ignore_sleeping", 32'(sleeping), 32'h1);
    chk("sleep_ignore_req", 32'(bus.im_req), 32'h0);
    irq_take = 1'b1; irq_vec = 32'h80;
    #1;
    chk("wake_req_off", 32'(bus.im_req), 32'h0);
    cyc();
    irq_take = 1'b0;
    #1;
    chk("wake_sleeping", 32'(sleeping), 32'h0);
    chk("wake_req", 32'(bus.im_req), 32'h1);
    chk("wake_addr", bus.im_addr, 32'h80);
    wait_valid("wake_tgt", 32'h80);

    // Reset mid-stream takes effect asynchronously
    repeat (3) cyc();
    rst = 1'b1;
    #1;
    chk("arst_id_valid", 32'(bus.id_valid), 32'h0);
    chk("arst_im_req", 32'(bus.im_req), 32'h0);
    chk("arst_sleeping", 32'(sleeping), 32'h0);
    lat = 1;
    do_reset();
    chk("post_rst_req", 32'(bus.im_req), 32'h1);
    chk("post_rst_addr", bus.im_addr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_prefetch_stage.md
Name: if_prefetch_stage

Overview:
Parametrised instruction-fetch stage for the RV32 core pipeline, sitting between the instruction-memory port (IM wrapper/AXI master) and the ID stage.
- Issues pipelined fetch requests with a req/gnt + rvalid handshake.
- Buffers returned instructions in a FQ_DEPTH-entry prefetch queue and presents them to ID with valid/ready.
- Handles redirects (interrupt, MRET, branch/jump) using epoch-free drop counting, so stale in-flight responses are discarded.
- Supports WFI sleep with interrupt wake-up.

Parameters:
XLEN, 32, address/instruction width
FQ_DEPTH, 4, prefetch queue entries (power of 2, >=2)
MAX_OUTST, 2, maximum fetches issued but not yet returned (>=1)
RESET_PC, 32'h0000_0000, PC after reset

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
im_req  out  1  fetch request valid
im_addr  out  XLEN  fetch byte address, word aligned
im_gnt  in  1  request accepted this cycle
im_rvalid  in  1  response valid, in order, minimum 1 cycle after gnt
im_rdata  in  XLEN  fetched instruction
irq_take  in  1  take interrupt, redirect to irq_vec
irq_vec  in  XLEN  mtvec target
mret  in  1  return, redirect to mepc
mepc  in  XLEN  MRET target
br_taken  in  1  branch/jump resolved taken
br_target  in  XLEN  branch target (pc+imm or rs1+imm, masked [1:0]=0)
wfi_req  in  1  enter WFI sleep
id_valid  out  1  instruction available to ID
id_pc  out  XLEN  PC of head instruction
id_inst  out  XLEN  head instruction
id_ready  in  1  ID accepts (low = hazard/stall keep)
sleeping  out  1  in WFI sleep

Behaviour:
- Reset values: state=RUN, pc=RESET_PC, queue empty, outst=0, drop=0, im_req=0 during reset; id_valid=0, id_pc=0, id_inst=0, sleeping=0.
- Credit rule: im_req=1 in RUN when (q_count + outst) < FQ_DEPTH, outst < MAX_OUTST, and no redirect is active this cycle. im_addr=pc.
- On im_req&&im_gnt: pc<=pc+4 (wraps modulo 2^XLEN), outst++.
- Unsent req may be dropped or readdressed; no hold-until-gnt obligation.
- On im_rvalid:
  - if drop>0: discard, drop--, outst--;
  - else push {resp_pc, im_rdata}, outst--.
  - resp_pc comes from an internal MAX_OUTST-deep PC FIFO written at gnt.
- Pop when id_valid&&id_ready. Push and pop in the same cycle are allowed at full or empty. No combinational im_rdata->id_inst path: minimum gnt->id_valid latency is 2 cycles.
- Redirect priority: irq_take > mret > br_taken. On a redirect:
  - pc<=target;
  - queue flushed;
  - drop<=outst minus any same-cycle rvalid consumption;
  - the response's PC FIFO entry is still popped;
  - im_req=0 that cycle, target issued next cycle at earliest.
- A redirect coincident with pop is allowed: the pop completes, then the flush.
- States:
  - RUN: wfi_req -> DRAIN.
  - DRAIN: no new requests; queue kept; when outst==0 and queue empty -> SLEEP.
  - SLEEP: sleeping=1, im_req=0.
  - irq_take in any state -> RUN with redirect to irq_vec.
  - mret/br_taken in DRAIN or SLEEP are ignored.
- Reset mid-transaction: all counters cleared; subsequent rvalid for pre-reset requests is the memory side's responsibility (it is reset too).
- Assertions: outst<=MAX_OUTST; q_count<=FQ_DEPTH; im_rvalid never when outst==0.

Optional Feature:
IF_PERF_CNT_EN
- Defined: adds outputs perf_fetch_cnt[31:0] (granted requests), perf_bubble_cnt[31:0] (cycles id_ready=1 && id_valid=0 in RUN) and perf_drop_cnt[31:0] (discarded responses). All reset to 0 and saturate at 2^32-1.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package if_pkg:
  - typedef fq_entry_t {pc, inst};
  - enum if_state_e {RUN, DRAIN, SLEEP};
  - NOP constant 32'h0000_0013;
  - redirect-source enum.
- One sub-module: if_fifo (parametrised width/depth synchronous FIFO with flush, count, full/empty). Instantiated for the prefetch queue and the in-flight PC FIFO.

Test Plan:
- Streaming, gnt=1, rvalid 1 cycle after gnt, id_ready=1 -> id_pc sequence 0,4,8,C..., id_valid continuous after the initial 2-cycle latency.
- id_ready=0 for 10 cycles -> exactly FQ_DEPTH=4 entries buffered, im_req drops; on release, pops 0,4,8,C in order with no loss.
- br_taken target 0x100 while 2 requests are outstanding -> both responses dropped (drop_cnt 2), queue flushed, next id_pc=0x100.
- irq_take (irq_vec=0x200) and br_taken in the same cycle -> irq wins, next id_pc=0x200; later mret (mepc=0x40) -> id_pc=0x40.
- wfi_req with 2 outstanding -> DRAIN until both return and are popped, then sleeping=1, im_req=0; irq_take -> sleeping=0, fetch at irq_vec.
- rst asserted mid-stream -> id_valid, im_req and sleeping go to 0 immediately; after release, first request has im_addr=RESET_PC.
